// File: rtl/fir_xifu_wb.sv
// Write-back stage of the FIR XIFU coprocessor: holds one EX/WB instruction,
// tracks its commit/kill, writes the XIFU register file and returns one X-interface result.
module fir_xifu_wb #(
    parameter int ID_W = 4,
    parameter int NREG = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    clear_i,
    input  logic                    ex_valid_i,
    input  logic [1:0]              ex_instr_i,
    input  logic [ID_W-1:0]         ex_id_i,
    input  logic [$clog2(NREG)-1:0] ex_rd_i,
    input  logic [4:0]              ex_rs1_i,
    input  logic [31:0]             ex_result_i,
    input  logic                    commit_valid_i,
    input  logic [ID_W-1:0]         commit_id_i,
    input  logic                    commit_kill_i,
    input  logic                    mem_result_valid_i,
    input  logic [ID_W-1:0]         mem_result_id_i,
    input  logic [31:0]             mem_result_rdata_i,
    input  logic                    result_ready_i,
    output logic                    result_valid_o,
    output logic [ID_W-1:0]         result_id_o,
    output logic [31:0]             result_data_o,
    output logic [4:0]              result_rd_o,
    output logic                    result_we_o,
    output logic                    rf_we_o,
    output logic [$clog2(NREG)-1:0] rf_waddr_o,
    output logic [31:0]             rf_wdata_o,
    output logic                    ready_o
);

    localparam int RW = $clog2(NREG);

    localparam logic [1:0] OP_NONE = 2'd0;
    localparam logic [1:0] OP_LW   = 2'd1;
    localparam logic [1:0] OP_SW   = 2'd2;
    localparam logic [1:0] OP_DOTP = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WAIT_CMT,
        RESP
    } state_e;

    state_e          state_q, state_d;
    logic            ready_q;
    logic [1:0]      instr_q;
    logic [ID_W-1:0] id_q;
    logic [RW-1:0]   rd_q;
    logic [4:0]      rs1_q;
    logic [31:0]     result_q;
    logic [31:0]     rdata_q;
    logic            committed_q;
    logic            killed_q;

    logic accept;
    logic commit_hit_ex;
    logic commit_hit_held;
    logic mem_hit;

    assign accept          = ex_valid_i && ready_q && (ex_instr_i != OP_NONE) && !clear_i;
    assign commit_hit_ex   = commit_valid_i && (commit_id_i == ex_id_i);
    assign commit_hit_held = commit_valid_i && (commit_id_i == id_q);
    assign mem_hit         = mem_result_valid_i && (mem_result_id_i == id_q);

    // ready is registered so it reads 0 while in reset and settles one edge after release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) state_d = (ex_instr_i == OP_LW) ? WAIT_MEM : WAIT_CMT;
                end
                WAIT_MEM: begin
                    if (mem_hit) state_d = WAIT_CMT;
                end
                WAIT_CMT: begin
                    if (killed_q)         state_d = IDLE;
                    else if (committed_q) state_d = RESP;
                end
                RESP: begin
                    if (result_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // A kill seen while waiting for memory is only recorded; the load still has to drain
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q     <= OP_NONE;
            id_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            result_q    <= '0;
            rdata_q     <= '0;
            committed_q <= 1'b0;
            killed_q    <= 1'b0;
        end else if (clear_i) begin
            instr_q     <= OP_NONE;
            id_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            result_q    <= '0;
            rdata_q     <= '0;
            committed_q <= 1'b0;
            killed_q    <= 1'b0;
        end else if (accept) begin
            instr_q     <= ex_instr_i;
            id_q        <= ex_id_i;
            rd_q        <= ex_rd_i;
            rs1_q       <= ex_rs1_i;
            result_q    <= ex_result_i;
            rdata_q     <= '0;
            committed_q <= commit_hit_ex && !commit_kill_i;
            killed_q    <= commit_hit_ex && commit_kill_i;
        end else if (state_q == WAIT_MEM || state_q == WAIT_CMT) begin
            if (state_q == WAIT_MEM && mem_hit) rdata_q <= mem_result_rdata_i;
            if (commit_hit_held && !commit_kill_i) committed_q <= 1'b1;
            if (commit_hit_held && commit_kill_i)  killed_q    <= 1'b1;
        end
    end

    always_comb begin
        ready_o        = ready_q;
        rf_we_o        = 1'b0;
        rf_waddr_o     = '0;
        rf_wdata_o     = '0;
        result_valid_o = 1'b0;
        result_id_o    = '0;
        result_data_o  = '0;
        result_rd_o    = '0;
        result_we_o    = 1'b0;
        if (!clear_i) begin
            if (state_q == WAIT_CMT && committed_q && !killed_q && instr_q != OP_SW) begin
                rf_we_o    = 1'b1;
                rf_waddr_o = rd_q;
                rf_wdata_o = (instr_q == OP_LW) ? rdata_q : result_q;
            end
            if (state_q == RESP) begin
                result_valid_o = 1'b1;
                result_id_o    = id_q;
                result_data_o  = result_q;
                result_rd_o    = rs1_q;
                result_we_o    = (instr_q != OP_DOTP);
            end
        end
    end

endmodule

// File: tb/tb_fir_xifu_wb.sv
// Self-checking bench for fir_xifu_wb: directed scenarios with literal expectations,
// then random traffic compared every cycle against a transaction-level model.
module tb_fir_xifu_wb;

    localparam int ID_W = 4;
    localparam int NREG = 8;

    logic            clk;
    logic            rst_n;
    logic            clear;
    logic            ex_valid;
    logic [1:0]      ex_instr;
    logic [ID_W-1:0] ex_id;
    logic [2:0]      ex_rd;
    logic [4:0]      ex_rs1;
    logic [31:0]     ex_result;
    logic            commit_valid;
    logic [ID_W-1:0] commit_id;
    logic            commit_kill;
    logic            mem_valid;
    logic [ID_W-1:0] mem_id;
    logic [31:0]     mem_rdata;
    logic            result_ready;
    logic            result_valid;
    logic [ID_W-1:0] result_id;
    logic [31:0]     result_data;
    logic [4:0]      result_rd;
    logic            result_we;
    logic            rf_we;
    logic [2:0]      rf_waddr;
    logic [31:0]     rf_wdata;
    logic            ready;

    int checks = 0;
    int errors = 0;

    fir_xifu_wb #(.ID_W(ID_W), .NREG(NREG)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .clear_i            (clear),
        .ex_valid_i         (ex_valid),
        .ex_instr_i         (ex_instr),
        .ex_id_i            (ex_id),
        .ex_rd_i            (ex_rd),
        .ex_rs1_i           (ex_rs1),
        .ex_result_i        (ex_result),
        .commit_valid_i     (commit_valid),
        .commit_id_i        (commit_id),
        .commit_kill_i      (commit_kill),
        .mem_result_valid_i (mem_valid),
        .mem_result_id_i    (mem_id),
        .mem_result_rdata_i (mem_rdata),
        .result_ready_i     (result_ready),
        .result_valid_o     (result_valid),
        .result_id_o        (result_id),
        .result_data_o      (result_data),
        .result_rd_o        (result_rd),
        .result_we_o        (result_we),
        .rf_we_o            (rf_we),
        .rf_waddr_o         (rf_waddr),
        .rf_wdata_o         (rf_wdata),
        .ready_o            (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Transaction-level model: one outstanding instruction plus what is known about it
    bit              m_armed, m_busy, m_have, m_cmt, m_kil, m_resp;
    logic [1:0]      m_instr;
    logic [ID_W-1:0] m_id;
    logic [2:0]      m_rd;
    logic [4:0]      m_rs1;
    logic [31:0]     m_res, m_mdata;

    task checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        m_armed = 0; m_busy = 0; m_have = 0; m_cmt = 0; m_kil = 0; m_resp = 0;
        m_instr = 0; m_id = 0; m_rd = 0; m_rs1 = 0; m_res = 0; m_mdata = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_armed = 0; m_busy = 0; m_have = 0; m_cmt = 0; m_kil = 0; m_resp = 0;
            end else begin
                bit pre_ready, hit;
                pre_ready = m_armed && !m_busy;
                m_armed = 1;
                if (clear) begin
                    m_busy = 0; m_resp = 0; m_cmt = 0; m_kil = 0;
                end else if (!m_busy) begin
                    if (ex_valid && pre_ready && ex_instr != 2'd0) begin
                        m_instr = ex_instr; m_id = ex_id; m_rd = ex_rd;
                        m_rs1 = ex_rs1; m_res = ex_result;
                        m_busy = 1; m_resp = 0;
                        m_have = (ex_instr != 2'd1);
                        m_cmt = commit_valid && commit_id == ex_id && !commit_kill;
                        m_kil = commit_valid && commit_id == ex_id && commit_kill;
                    end
                end else if (m_resp) begin
                    if (result_ready) m_busy = 0;
                end else begin
                    hit = commit_valid && commit_id == m_id;
                    if (m_have) begin
                        if (m_kil)      m_busy = 0;
                        else if (m_cmt) m_resp = 1;
                    end else if (mem_valid && mem_id == m_id) begin
                        m_mdata = mem_rdata;
                        m_have = 1;
                    end
                    if (hit && commit_kill)  m_kil = 1;
                    if (hit && !commit_kill) m_cmt = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        bit e_rf, e_rv;
        e_rf = m_busy && !m_resp && m_have && m_cmt && !m_kil && m_instr != 2'd2 && !clear;
        e_rv = m_busy && m_resp && !clear;
        checkOutput("ready_o", {31'd0, ready}, {31'd0, m_armed && !m_busy});
        checkOutput("rf_we_o", {31'd0, rf_we}, {31'd0, e_rf});
        checkOutput("rf_waddr_o", {29'd0, rf_waddr}, e_rf ? {29'd0, m_rd} : 32'd0);
        checkOutput("rf_wdata_o", rf_wdata, e_rf ? ((m_instr == 2'd1) ? m_mdata : m_res) : 32'd0);
        checkOutput("result_valid_o", {31'd0, result_valid}, {31'd0, e_rv});
        checkOutput("result_id_o", {28'd0, result_id}, e_rv ? {28'd0, m_id} : 32'd0);
        checkOutput("result_data_o", result_data, e_rv ? m_res : 32'd0);
        checkOutput("result_rd_o", {27'd0, result_rd}, e_rv ? {27'd0, m_rs1} : 32'd0);
        checkOutput("result_we_o", {31'd0, result_we}, {31'd0, e_rv && m_instr != 2'd3});
    end

    task idleInputs();
        clear = 0; ex_valid = 0; ex_instr = 0; ex_id = 0; ex_rd = 0; ex_rs1 = 0; ex_result = 0;
        commit_valid = 0; commit_id = 0; commit_kill = 0;
        mem_valid = 0; mem_id = 0; mem_rdata = 0; result_ready = 1;
    endtask

    task tick();
        @(posedge clk);
        #1;
    endtask

    task setEx(input logic [1:0] instr, input logic [3:0] id, input logic [2:0] rd,
               input logic [4:0] rs1, input logic [31:0] res);
        ex_valid = 1; ex_instr = instr; ex_id = id; ex_rd = rd; ex_rs1 = rs1; ex_result = res;
    endtask

    task setCommit(input logic [3:0] id, input logic kill);
        commit_valid = 1; commit_id = id; commit_kill = kill;
    endtask

    task setMem(input logic [3:0] id, input logic [31:0] data);
        mem_valid = 1; mem_id = id; mem_rdata = data;
    endtask

    task applyStimulus();
        idleInputs();
        ex_valid  = 1'($urandom_range(0, 1));
        ex_instr  = 2'($urandom_range(0, 3));
        ex_id     = 4'($urandom_range(0, 15));
        ex_rd     = 3'($urandom_range(0, 7));
        ex_rs1    = 5'($urandom_range(0, 31));
        ex_result = $urandom;
        if (!m_busy) begin
            if (ex_valid && $urandom_range(0, 4) == 0) setCommit(ex_id, 1'($urandom_range(0, 6) == 0));
        end else if (!m_cmt && !m_kil && !m_resp && $urandom_range(0, 3) == 0) begin
            setCommit(m_id, 1'($urandom_range(0, 6) == 0));
        end else if ($urandom_range(0, 9) == 0) begin
            setCommit(m_id ^ 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
        end
        if (m_busy && m_instr == 2'd1 && !m_have && $urandom_range(0, 2) == 0)
            setMem(m_id, $urandom);
        else if ($urandom_range(0, 7) == 0)
            setMem(4'($urandom_range(0, 15)), $urandom);
        result_ready = ($urandom_range(0, 9) < 7);
        clear = ($urandom_range(0, 99) == 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idleInputs();
        rst_n = 1;
        #2 rst_n = 0;
        #1;
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_result_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("reset_rf_we", {31'd0, rf_we}, 32'd0);
        tick(); tick();
        rst_n = 1;
        tick();
        checkOutput("ready_after_reset", {31'd0, ready}, 32'd1);

        // DOTP committed in the accept cycle
        setEx(2'd3, 4'd3, 3'd2, 5'd7, 32'h0000_1234); setCommit(4'd3, 0);
        #1 checkOutput("dotp_accept_ready", {31'd0, ready}, 32'd1);
        tick(); idleInputs();
        #1 checkOutput("dotp_rf_we", {31'd0, rf_we}, 32'd1);
        checkOutput("dotp_rf_waddr", {29'd0, rf_waddr}, 32'd2);
        checkOutput("dotp_rf_wdata", rf_wdata, 32'h0000_1234);
        tick();
        #1 checkOutput("dotp_result_valid", {31'd0, result_valid}, 32'd1);
        checkOutput("dotp_result_id", {28'd0, result_id}, 32'd3);
        checkOutput("dotp_result_we", {31'd0, result_we}, 32'd0);
        checkOutput("dotp_rf_we_once", {31'd0, rf_we}, 32'd0);
        tick();
        #1 checkOutput("dotp_ready_again", {31'd0, ready}, 32'd1);

        // LW, commit before the memory result
        setEx(2'd1, 4'd1, 3'd5, 5'd10, 32'h0000_1004);
        tick(); idleInputs(); setCommit(4'd1, 0);
        tick(); idleInputs();
        tick(); setMem(4'd1, 32'hCAFE_BABE);
        #1 checkOutput("lw_wait_ready", {31'd0, ready}, 32'd0);
        tick(); idleInputs();
        #1 checkOutput("lw_rf_we", {31'd0, rf_we}, 32'd1);
        checkOutput("lw_rf_waddr", {29'd0, rf_waddr}, 32'd5);
        checkOutput("lw_rf_wdata", rf_wdata, 32'hCAFE_BABE);
        tick();
        #1 checkOutput("lw_result_data", result_data, 32'h0000_1004);
        checkOutput("lw_result_rd", {27'd0, result_rd}, 32'd10);
        checkOutput("lw_result_we", {31'd0, result_we}, 32'd1);
        tick();

        // SW with late commit and back-pressure
        setEx(2'd2, 4'd2, 3'd0, 5'd3, 32'h0000_2008); result_ready = 0;
        for (int i = 0; i < 4; i++) begin
            tick(); idleInputs(); result_ready = 0;
        end
        setCommit(4'd2, 0);
        tick(); idleInputs(); result_ready = 0;
        #1 checkOutput("sw_no_rf_we", {31'd0, rf_we}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); result_ready = 0;
            #1 checkOutput("sw_held_valid", {31'd0, result_valid}, 32'd1);
            checkOutput("sw_held_data", result_data, 32'h0000_2008);
        end
        tick(); result_ready = 1;
        #1 checkOutput("sw_handshake_valid", {31'd0, result_valid}, 32'd1);
        tick();
        #1 checkOutput("sw_done_valid", {31'd0, result_valid}, 32'd0);

        // LW killed while waiting; foreign mem result ignored
        setEx(2'd1, 4'd4, 3'd3, 5'd9, 32'h0000_3000);
        tick(); idleInputs(); setCommit(4'd4, 1);
        tick(); idleInputs(); setMem(4'd7, 32'hDEAD_0007);
        tick(); idleInputs();
        #1 checkOutput("kill_still_waiting", {31'd0, ready}, 32'd0);
        setMem(4'd4, 32'h4444_4444);
        tick(); idleInputs();
        #1 checkOutput("kill_no_rf_we", {31'd0, rf_we}, 32'd0);
        tick();
        #1 checkOutput("kill_idle_ready", {31'd0, ready}, 32'd1);
        checkOutput("kill_no_result", {31'd0, result_valid}, 32'd0);

        // clear during RESP
        setEx(2'd3, 4'd5, 3'd1, 5'd4, 32'h0000_ABCD); setCommit(4'd5, 0); result_ready = 0;
        tick(); idleInputs(); result_ready = 0;
        #1 checkOutput("clr_rf_wdata", rf_wdata, 32'h0000_ABCD);
        tick(); result_ready = 0; clear = 1;
        #1 checkOutput("clr_gates_result", {31'd0, result_valid}, 32'd0);
        tick(); idleInputs();
        #1 checkOutput("clr_ready", {31'd0, ready}, 32'd1);
        checkOutput("clr_no_dup_rf_we", {31'd0, rf_we}, 32'd0);

        // asynchronous reset in WAIT_MEM, then a clean DOTP
        setEx(2'd1, 4'd6, 3'd2, 5'd5, 32'h0000_5000);
        tick(); idleInputs();
        #1 rst_n = 0;
        #1 checkOutput("rst_mid_ready", {31'd0, ready}, 32'd0);
        checkOutput("rst_mid_valid", {31'd0, result_valid}, 32'd0);
        checkOutput("rst_mid_data", result_data, 32'd0);
        tick(); rst_n = 1;
        tick();
        setEx(2'd3, 4'd8, 3'd6, 5'd12, 32'h0000_600D); setCommit(4'd8, 0);
        tick(); idleInputs();
        #1 checkOutput("post_rst_rf_wdata", rf_wdata, 32'h0000_600D);
        checkOutput("post_rst_rf_waddr", {29'd0, rf_waddr}, 32'd6);
        tick();
        #1 checkOutput("post_rst_result_id", {28'd0, result_id}, 32'd8);
        tick();

        for (int c = 0; c < 3000; c++) begin
            applyStimulus();
            tick();
        end
        idleInputs();
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fir_xifu_wb.md
Name: fir_xifu_wb

Overview:
- Write-back stage of the FIR XIFU coprocessor, directly downstream of the EX stage; consumes the registered EX/WB bundle.
- For XFIRLW: waits for the core LSU memory result, then writes the loaded word into the XIFU register file.
- For XFIRDOTP: writes the dot-product result into the XIFU register file.
- For every committed instruction, issues exactly one X-interface result to the core; XFIRLW/XFIRSW return the post-incremented address for core GPR rs1.

Parameters:
- ID_W, 4, width of the X-interface instruction ID.
- NREG, 8, number of XIFU registers; register index width is $clog2(NREG).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- clear_i  in  1  synchronous flush; returns FSM to IDLE and drops the held instruction.
- ex_valid_i  in  1  EX/WB bundle holds a valid instruction.
- ex_instr_i  in  2  opcode: NONE=0, XFIRLW=1, XFIRSW=2, XFIRDOTP=3.
- ex_id_i  in  ID_W  instruction ID.
- ex_rd_i  in  $clog2(NREG)  XIFU destination register.
- ex_rs1_i  in  5  core GPR receiving the post-increment address.
- ex_result_i  in  32  dot-product result (DOTP) or next address (LW/SW).
- commit_valid_i  in  1  core commit strobe.
- commit_id_i  in  ID_W  ID being committed.
- commit_kill_i  in  1  commit is a kill.
- mem_result_valid_i  in  1  LSU load data valid.
- mem_result_id_i  in  ID_W  ID of load data.
- mem_result_rdata_i  in  32  load data.
- result_ready_i  in  1  core accepts X-interface result.
- result_valid_o  out  1  X-interface result valid.
- result_id_o  out  ID_W  result ID.
- result_data_o  out  32  data for core GPR.
- result_rd_o  out  5  core GPR index (= held rs1).
- result_we_o  out  1  core GPR write enable.
- rf_we_o  out  1  XIFU register-file write enable (single-cycle pulse).
- rf_waddr_o  out  $clog2(NREG)  XIFU register-file write address.
- rf_wdata_o  out  32  XIFU register-file write data.
- ready_o  out  1  WB can accept a new EX bundle this cycle (drives EX ready_i).

Behaviour:
- Reset: all outputs 0, FSM=IDLE, holding register cleared, committed/killed flags 0.
- Holding register captures {instr, id, rd, rs1, result} when ex_valid_i && ready_o && instr!=NONE.
- ready_o = 1 only in IDLE. NONE bundles are accepted and ignored.
- Commit tracking:
  - committed flag sets when commit_valid_i && !commit_kill_i && commit_id_i==held id.
  - killed flag sets on the same match with kill asserted.
  - A commit matching ex_id_i in the accept cycle is captured the same cycle.
- States and transitions:
  - IDLE: on accept, LW -> WAIT_MEM; SW/DOTP -> WAIT_CMT.
  - WAIT_MEM: on mem_result_valid_i with mem_result_id_i==held id, latch rdata -> WAIT_CMT. Non-matching IDs are ignored.
  - WAIT_CMT:
    - If killed: no rf write, no result -> IDLE.
    - If committed: one-cycle rf_we_o pulse for LW (wdata=rdata) and DOTP (wdata=held result), waddr=held rd; SW produces no rf write. Then -> RESP.
  - RESP: result_valid_o=1, result_id_o=held id, result_rd_o=held rs1.
    - LW/SW: result_data_o=held result (next address), result_we_o=1.
    - DOTP: result_data_o=held result, result_we_o=0.
    - Outputs held stable while result_ready_i=0; on handshake -> IDLE.
- Kill in RESP: ignored, because the result is already committed.
- Kill in WAIT_MEM: the killed flag is set, but the stage still waits for the matching mem result to drain the LSU transaction, then drops it.
- Minimum latency:
  - DOTP/SW committed on accept: rf write in cycle +1, result valid in cycle +2.
  - LW: +1 cycle after the mem result.
- clear_i has priority over everything except reset: FSM -> IDLE, flags cleared, no rf write or result that cycle.
- Asynchronous reset mid-operation aborts the transaction immediately; all outputs are 0.

Test Plan:
- DOTP id=3, rd=2, result=0x0000_1234, committed in accept cycle, result_ready_i=1 -> rf_we_o pulse (addr 2, data 0x1234) at +1; result valid at +2 (id 3, we=0); ready_o high at +3.
- LW id=1, rd=5, rs1=10, result=0x1004; mem result id=1 data 0xCAFEBABE arrives 3 cycles later, commit earlier -> rf write r5=0xCAFEBABE; result data 0x1004, rd 10, we=1.
- SW id=2, result=0x2008, commit arrives 4 cycles after accept, result_ready_i low for 3 cycles -> no rf write; result held stable for 3 cycles, handshake completes on the 4th.
- LW id=4 killed while in WAIT_MEM, mem result id=4 arrives afterwards -> no rf write, no result, returns to IDLE; a mem result with id=7 before it is ignored.
- clear_i asserted in RESP of a DOTP -> result_valid_o low the next cycle, ready_o=1, no duplicate rf write.
- rst_ni low mid-WAIT_MEM -> all outputs 0 immediately; after release, a DOTP completes normally.
